alu_muldiv_seq: RTL and testbench

- Parametrised, handshaked successor to the combinational datapath ALU.
- Executes the full MIPS R-type funct set at a configurable WIDTH and adds an iterative multiply/divide unit with architectural HI/LO registers and MFHI/MFLO.
- Single-cycle ops return one cycle after acceptance. MULT/DIV run multi-cycle and stall the issue handshake.
- Sits between the register-read stage and the writeback register of the multi-cycle CPU.

---
 rtl/alu_muldiv_seq_if.sv | 34 +++
 rtl/alu_muldiv_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the register-read stage and the ALU/muldiv unit.
// The slave side is the execution unit; the master side is the issuing stage.
interface alu_muldiv_seq_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [5:0]       funct;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero_flag;
   logic             negative_flag;
   logic             overflow_flag;
   logic             carry_flag;
   logic             div0_flag;
   logic             illegal_flag;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output in_valid, funct, a, b, out_ready,
      input  in_ready, out_valid, result, zero_flag, negative_flag, overflow_flag,
             carry_flag, div0_flag, illegal_flag, hi, lo
   );

   modport slave (
      input  in_valid, funct, a, b, out_ready,
      output in_ready, out_valid, result, zero_flag, negative_flag, overflow_flag,
             carry_flag, div0_flag, illegal_flag, hi, lo
   );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Handshaked MIPS R-type ALU with iterative shift-add multiplier, restoring divider
// and architectural HI/LO registers; single-cycle ops return on the accept edge.
module alu_muldiv_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_muldiv_seq_if.slave bus
);
   localparam logic [5:0] F_ADD  = 6'b100000, F_ADDU = 6'b100001, F_SUB  = 6'b100010;
   localparam logic [5:0] F_SUBU = 6'b100011, F_AND  = 6'b100100, F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR  = 6'b100110, F_NOR  = 6'b100111, F_SLT  = 6'b101010;
   localparam logic [5:0] F_SLTU = 6'b101011, F_SLLV = 6'b000100, F_SRLV = 6'b000110;
   localparam logic [5:0] F_SRAV = 6'b000111, F_CLZ  = 6'b011101, F_CLO  = 6'b011100;
   localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010, F_MULT = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011;
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t             state_q, state_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d, lo_q, lo_d;
   logic               zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
   logic               carry_q, carry_d, div0_q, div0_d, ill_q, ill_d;
   logic [WIDTH-1:0]   opa_q, opa_d, shr_q, shr_d;
   logic [WIDTH:0]     acc_q, acc_d;
   logic               qneg_q, qneg_d, rneg_q, rneg_d, dovf_q, dovf_d;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [SHW:0] lead_zeros(input logic [WIDTH-1:0] v);
      logic [SHW:0] n;
      logic         found;
      n     = '0;
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      n = n + 1'b1;
         end
      end
      return n;
   endfunction

   logic                    ready, accept, last, signed_op;
   logic signed [WIDTH-1:0] sa, sb;
   logic [WIDTH:0]          sum_w, dif_w;
   logic [SHW-1:0]          sh;
   logic [WIDTH-1:0]        alu_res;
   logic                    alu_ovf, alu_carry, alu_ill;

   assign ready     = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
   assign accept    = bus.in_valid && ready;
   assign last      = (cnt_q == SHW'(WIDTH - 1));
   assign signed_op = !bus.funct[0];
   assign sa        = bus.a;
   assign sb        = bus.b;
   assign sum_w     = {1'b0, bus.a} + {1'b0, bus.b};
   assign dif_w     = {1'b0, bus.a} - {1'b0, bus.b};
   assign sh        = bus.a[SHW-1:0];

   always_comb begin
      alu_res   = '0;
      alu_ovf   = 1'b0;
      alu_carry = 1'b0;
      alu_ill   = 1'b0;
      case (bus.funct)
         F_ADD:  begin alu_res = sum_w[WIDTH-1:0];
                       alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_w[WIDTH-1] != bus.a[WIDTH-1]); end
         F_SUB:  begin alu_res = dif_w[WIDTH-1:0];
                       alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif_w[WIDTH-1] != bus.a[WIDTH-1]); end
         F_ADDU: begin alu_res = sum_w[WIDTH-1:0]; alu_carry = sum_w[WIDTH]; end
         F_SUBU: begin alu_res = dif_w[WIDTH-1:0]; alu_carry = dif_w[WIDTH]; end
         F_AND:  alu_res = bus.a & bus.b;
         F_OR:   alu_res = bus.a | bus.b;
         F_XOR:  alu_res = bus.a ^ bus.b;
         F_NOR:  alu_res = ~(bus.a | bus.b);
         F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (sa < sb)};
         F_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
         F_SLLV: alu_res = bus.b << sh;
         F_SRLV: alu_res = bus.b >> sh;
         F_SRAV: alu_res = sb >>> sh;
         F_CLZ:  alu_res = {{(WIDTH-SHW-1){1'b0}}, lead_zeros(bus.a)};
         F_CLO:  alu_res = {{(WIDTH-SHW-1){1'b0}}, lead_zeros(~bus.a)};
         F_MFHI: alu_res = hi_q;
         F_MFLO: alu_res = lo_q;
         F_MULT, F_MULTU, F_DIV, F_DIVU: alu_res = '0;
         default: alu_ill = 1'b1;
      endcase
   end

   // Iteration datapath: multiplier keeps {acc, shr} as the shifting product,
   // divider keeps acc as partial remainder and shr as dividend/quotient.
   logic [WIDTH:0]     msum, rsh, rem_n;
   logic [WIDTH+1:0]   trial;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   quo_n, quo_fix, rem_fix;
   logic               ge;

   assign msum     = acc_q + (shr_q[0] ? {1'b0, opa_q} : '0);
   assign prod     = {msum, shr_q[WIDTH-1:1]};
   assign prod_fix = qneg_q ? -prod : prod;
   assign rsh      = {acc_q[WIDTH-1:0], shr_q[WIDTH-1]};
   assign trial    = {1'b0, rsh} - {2'b0, opa_q};
   assign ge       = !trial[WIDTH+1];
   assign rem_n    = ge ? trial[WIDTH:0] : rsh;
   assign quo_n    = {shr_q[WIDTH-2:0], ge};
   assign quo_fix  = qneg_q ? -quo_n : quo_n;
   assign rem_fix  = rneg_q ? -rem_n[WIDTH-1:0] : rem_n[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) begin
            if (bus.funct == F_MULT || bus.funct == F_MULTU) state_d = S_MUL;
            else if ((bus.funct == F_DIV || bus.funct == F_DIVU) && bus.b != '0) state_d = S_DIV;
         end
         S_MUL, S_DIV: if (last) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   logic             ld, ld_ovf, ld_carry, ld_div0, ld_ill;
   logic [WIDTH-1:0] ld_res;

   always_comb begin
      cnt_d = cnt_q;  out_valid_d = out_valid_q && !bus.out_ready;
      result_d = result_q;  hi_d = hi_q;  lo_d = lo_q;
      zero_d = zero_q;  neg_d = neg_q;  ovf_d = ovf_q;
      carry_d = carry_q;  div0_d = div0_q;  ill_d = ill_q;
      opa_d = opa_q;  acc_d = acc_q;  shr_d = shr_q;
      qneg_d = qneg_q;  rneg_d = rneg_q;  dovf_d = dovf_q;
      ld = 1'b0;  ld_res = '0;  ld_ovf = 1'b0;  ld_carry = 1'b0;  ld_div0 = 1'b0;  ld_ill = 1'b0;
      case (state_q)
         S_IDLE: if (accept) begin
            cnt_d = '0;
            if (bus.funct == F_MULT || bus.funct == F_MULTU) begin
               opa_d  = mag(bus.a, signed_op);
               shr_d  = mag(bus.b, signed_op);
               acc_d  = '0;
               qneg_d = signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            end else if (bus.funct == F_DIV || bus.funct == F_DIVU) begin
               if (bus.b == '0) begin
                  ld = 1'b1;  ld_res = '1;  ld_div0 = 1'b1;
                  hi_d = bus.a;  lo_d = '1;
               end else begin
                  opa_d  = mag(bus.b, signed_op);
                  shr_d  = mag(bus.a, signed_op);
                  acc_d  = '0;
                  qneg_d = signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  rneg_d = signed_op && bus.a[WIDTH-1];
                  dovf_d = signed_op && (bus.a == MIN_VAL) && (bus.b == '1);
               end
            end else begin
               ld = 1'b1;  ld_res = alu_res;  ld_ovf = alu_ovf;
               ld_carry = alu_carry;  ld_ill = alu_ill;
            end
         end
         S_MUL: begin
            cnt_d = cnt_q + 1'b1;
            acc_d = {1'b0, msum[WIDTH:1]};
            shr_d = {msum[0], shr_q[WIDTH-1:1]};
            if (last) begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];  lo_d = prod_fix[WIDTH-1:0];
               ld = 1'b1;  ld_res = prod_fix[WIDTH-1:0];
            end
         end
         S_DIV: begin
            cnt_d = cnt_q + 1'b1;
            acc_d = rem_n;
            shr_d = quo_n;
            if (last) begin
               hi_d = rem_fix;  lo_d = quo_fix;
               ld = 1'b1;  ld_res = quo_fix;  ld_ovf = dovf_q;
            end
         end
         default: ;
      endcase
      if (ld) begin
         out_valid_d = 1'b1;  result_d = ld_res;
         zero_d = (ld_res == '0);  neg_d = ld_res[WIDTH-1];
         ovf_d = ld_ovf;  carry_d = ld_carry;  div0_d = ld_div0;  ill_d = ld_ill;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;  out_valid_q <= 1'b0;  result_q <= '0;  hi_q <= '0;  lo_q <= '0;
         zero_q <= 1'b0;  neg_q <= 1'b0;  ovf_q <= 1'b0;
         carry_q <= 1'b0;  div0_q <= 1'b0;  ill_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;  out_valid_q <= out_valid_d;  result_q <= result_d;
         hi_q <= hi_d;  lo_q <= lo_d;
         zero_q <= zero_d;  neg_q <= neg_d;  ovf_q <= ovf_d;
         carry_q <= carry_d;  div0_q <= div0_d;  ill_q <= ill_d;
      end
   end

   always_ff @(posedge clk) begin
      opa_q <= opa_d;  acc_q <= acc_d;  shr_q <= shr_d;
      qneg_q <= qneg_d;  rneg_q <= rneg_d;  dovf_q <= dovf_d;
   end

   assign bus.in_ready      = ready;
   assign bus.out_valid     = out_valid_q;
   assign bus.result        = result_q;
   assign bus.zero_flag     = zero_q;
   assign bus.negative_flag = neg_q;
   assign bus.overflow_flag = ovf_q;
   assign bus.carry_flag    = carry_q;
   assign bus.div0_flag     = div0_q;
   assign bus.illegal_flag  = ill_q;
   assign bus.hi            = hi_q;
   assign bus.lo            = lo_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized bench for alu_muldiv_seq (WIDTH=32) against a plain-arithmetic
// reference model of the MIPS funct set, HI/LO and handshake timing.
module tb_alu_muldiv_seq;
   localparam logic [5:0] F_ADD  = 6'b100000, F_ADDU = 6'b100001, F_SUB  = 6'b100010;
   localparam logic [5:0] F_SUBU = 6'b100011, F_AND  = 6'b100100, F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR  = 6'b100110, F_NOR  = 6'b100111, F_SLT  = 6'b101010;
   localparam logic [5:0] F_SLTU = 6'b101011, F_SLLV = 6'b000100, F_SRLV = 6'b000110;
   localparam logic [5:0] F_SRAV = 6'b000111, F_CLZ  = 6'b011101, F_CLO  = 6'b011100;
   localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010, F_MULT = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011;
   localparam logic [5:0] FTAB [25] = '{
      F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU,
      F_SLLV, F_SRLV, F_SRAV, F_CLZ, F_CLO, F_MFHI, F_MFLO, F_MULT, F_MULTU,
      F_DIV, F_DIVU, F_DIV, 6'b001000, 6'b111111, 6'b000000};

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   logic [31:0] m_hi, m_lo, exp_res;
   logic [5:0]  exp_flags;
   int          exp_lat;

   alu_muldiv_seq_if #(.WIDTH(32)) bus ();
   alu_muldiv_seq #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] lead(input logic [31:0] v, input logic ones);
      int n;
      n = 0;
      while (n < 32 && v[31-n] == ones) n++;
      return 32'(n);
   endfunction

   // Expected outcome of one operation; also advances the model's HI/LO.
   task automatic model(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
      longint          sa, sb;
      longint unsigned ua, ub, p;
      logic [31:0]     r;
      logic            o, c, d, il;
      sa = $signed(av);  sb = $signed(bv);
      ua = {32'd0, av};  ub = {32'd0, bv};
      r = 32'd0;  o = 1'b0;  c = 1'b0;  d = 1'b0;  il = 1'b0;  exp_lat = 1;
      case (f)
         F_ADD:  begin r = av + bv; o = (sa + sb) != longint'($signed(r)); end
         F_SUB:  begin r = av - bv; o = (sa - sb) != longint'($signed(r)); end
         F_ADDU: begin r = av + bv; c = (ua + ub) > 64'hFFFF_FFFF; end
         F_SUBU: begin r = av - bv; c = ua < ub; end
         F_AND:  r = av & bv;
         F_OR:   r = av | bv;
         F_XOR:  r = av ^ bv;
         F_NOR:  r = ~(av | bv);
         F_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
         F_SLTU: r = (ua < ub) ? 32'd1 : 32'd0;
         F_SLLV: r = bv << av[4:0];
         F_SRLV: r = bv >> av[4:0];
         F_SRAV: r = 32'(sb >>> av[4:0]);
         F_CLZ:  r = lead(av, 1'b0);
         F_CLO:  r = lead(av, 1'b1);
         F_MFHI: r = m_hi;
         F_MFLO: r = m_lo;
         F_MULT, F_MULTU: begin
            p = (f == F_MULT) ? 64'(sa * sb) : ua * ub;
            m_hi = p[63:32];  m_lo = p[31:0];  r = m_lo;  exp_lat = 33;
         end
         F_DIV, F_DIVU: begin
            if (bv == 32'd0) begin
               d = 1'b1;  m_lo = 32'hFFFF_FFFF;  m_hi = av;
            end else if (f == F_DIV && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
               o = 1'b1;  m_lo = 32'h8000_0000;  m_hi = 32'd0;  exp_lat = 33;
            end else if (f == F_DIV) begin
               m_lo = 32'(sa / sb);  m_hi = 32'(sa % sb);  exp_lat = 33;
            end else begin
               m_lo = 32'(ua / ub);  m_hi = 32'(ua % ub);  exp_lat = 33;
            end
            r = m_lo;
         end
         default: il = 1'b1;
      endcase
      exp_res   = r;
      exp_flags = {o, c, (r == 32'd0), r[31], d, il};
   endtask

   task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] av,
                         input logic [31:0] bv);
      int lat;
      model(f, av, bv);
      @(negedge clk);
      bus.in_valid = 1'b1;  bus.funct = f;  bus.a = av;  bus.b = bv;  bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;  bus.funct = 6'($urandom);  bus.a = $urandom;  bus.b = $urandom;
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
         bus.a = $urandom;  bus.b = $urandom;
      end
      check_val({tag, ".lat"}, lat, exp_lat);
      check_val({tag, ".res"}, bus.result, exp_res);
      check_val({tag, ".flags"}, {bus.overflow_flag, bus.carry_flag, bus.zero_flag,
                bus.negative_flag, bus.div0_flag, bus.illegal_flag}, exp_flags);
      check_val({tag, ".hi"}, bus.hi, m_hi);
      check_val({tag, ".lo"}, bus.lo, m_lo);
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] edge_vals [6];
      edge_vals = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd35};
      if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 5)];
      return $urandom;
   endfunction

   initial begin
      n_checks = 0;  n_errors = 0;  m_hi = 32'd0;  m_lo = 32'd0;
      rst_n = 1'b0;  bus.in_valid = 1'b0;  bus.out_ready = 1'b1;
      bus.funct = 6'd0;  bus.a = 32'd0;  bus.b = 32'd0;
      #22;
      check_val("rst.out_valid", bus.out_valid, 0);
      check_val("rst.result", bus.result, 0);
      check_val("rst.flags", {bus.overflow_flag, bus.carry_flag, bus.zero_flag,
                bus.negative_flag, bus.div0_flag, bus.illegal_flag}, 0);
      check_val("rst.hilo", {bus.hi, bus.lo}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_val("rst.in_ready", bus.in_ready, 1);

      run_op("add_ovf", F_ADD, 32'h7FFF_FFFF, 32'd1);
      check_val("add_ovf.const", {bus.result, 6'(bus.overflow_flag)}, {32'h8000_0000, 6'd1});
      run_op("subu", F_SUBU, 32'd3, 32'd5);
      check_val("subu.const", {bus.result, 6'(bus.carry_flag)}, {32'hFFFF_FFFE, 6'd1});
      run_op("addu", F_ADDU, 32'hFFFF_FFFF, 32'd1);
      run_op("mult", F_MULT, 32'hFFFF_FFFD, 32'd7);
      check_val("mult.const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op("mfhi", F_MFHI, 32'd0, 32'd0);
      run_op("div", F_DIV, 32'hFFFF_FFF9, 32'd2);
      check_val("div.const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("divu0", F_DIVU, 32'd1234, 32'd0);
      run_op("divmin", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      check_val("divmin.const", {bus.hi, bus.lo, 6'(bus.overflow_flag)},
                {64'h0000_0000_8000_0000, 6'd1});
      run_op("clz", F_CLZ, 32'h0001_0000, 32'd0);
      check_val("clz.const", bus.result, 15);
      run_op("clo", F_CLO, 32'hFFFF_FFFF, 32'd0);
      check_val("clo.const", bus.result, 32);
      run_op("srav", F_SRAV, 32'd35, 32'h8000_0000);
      check_val("srav.const", bus.result, 32'hF000_0000);
      run_op("multu", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("mflo", F_MFLO, 32'd0, 32'd0);
      run_op("illegal", 6'b111110, 32'd5, 32'd6);

      // Back-to-back issue, one op per cycle.
      for (int i = 0; i < 4; i++) begin
         logic [31:0] av, bv;
         av = $urandom;  bv = $urandom;
         model(FTAB[i * 3], av, bv);
         @(negedge clk);
         check_val("b2b.ready", bus.in_ready, 1);
         bus.in_valid = 1'b1;  bus.funct = FTAB[i * 3];  bus.a = av;  bus.b = bv;
         @(posedge clk);
         #1;
         check_val("b2b.valid", bus.out_valid, 1);
         check_val("b2b.res", bus.result, exp_res);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;

      // Output stall: result must hold while the consumer is not ready.
      model(F_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
      @(negedge clk);
      bus.in_valid = 1'b1;  bus.funct = F_AND;  bus.a = 32'hF0F0_1234;  bus.b = 32'h0FF0_FF00;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.funct = F_ADD;  bus.a = 32'd1;  bus.b = 32'd2;
      check_val("hold.valid0", bus.out_valid, 1);
      check_val("hold.res0", bus.result, exp_res);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check_val("hold.res", bus.result, exp_res);
         check_val("hold.ready", bus.in_ready, 0);
         check_val("hold.valid", bus.out_valid, 1);
      end
      bus.in_valid = 1'b0;  bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_val("hold.release", bus.out_valid, 0);

      for (int i = 0; i < 150; i++) begin
         int k;
         k = $urandom_range(0, 24);
         run_op("rnd", FTAB[k], pick(), pick());
      end

      // Reset in the middle of a multiply after HI/LO already hold a value.
      run_op("pre_rst", F_MULT, 32'hFFFF_FFFD, 32'd7);
      @(negedge clk);
      bus.in_valid = 1'b1;  bus.funct = F_MULT;  bus.a = 32'd12345;  bus.b = 32'd678;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("midrst.valid", bus.out_valid, 0);
      check_val("midrst.hilo", {bus.hi, bus.lo}, 0);
      check_val("midrst.result", bus.result, 0);
      m_hi = 32'd0;  m_lo = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst", F_MFHI, 32'd0, 32'd0);
      run_op("post_rst2", F_MFLO, 32'd0, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
